fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register, and the source of that register's next-PC input.
- Each cycle it presents the current PC to instruction memory over a valid/ready request channel and captures the returned word.
- It delivers {instr, pc, pc+4} to decode through a valid/ready pipeline register backed by a one-entry skid buffer.
- It computes npc: hold, sequential pc+4, or redirect target from a later stage.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_skid_buf.sv | 53 +++++
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the instruction-fetch slice.
//   fetch_state_t         - fetch FSM encoding (request, wait for word, drop stale word)
//   NOP_INSTR             - instruction placed in the decode register on reset/flush
//   DEFAULT_RESET_VECTOR  - default PC presented to the PC register during reset
//   pc_plus4()            - 32-bit modulo sequential-PC increment
package mips_pkg;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Wraps 0xFFFF_FFFC to 0x0000_0000 naturally through 32-bit truncation.
  function automatic logic [31:0] pc_plus4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: handshake bundle around the fetch stage.
//   imem_req_*  - fetch request channel toward instruction memory (valid/ready)
//   imem_rsp_*  - instruction word returning from memory (always accepted)
//   if_*        - fetched {instr, pc, pc+4} toward decode, id_ready is decode's ready
// master = fetch unit side, slave = memory/decode environment side.
interface fetch_unit_if;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        id_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_instr, if_pc, if_pc4,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_instr, if_pc, if_pc4,
    output id_ready
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr, pc} holding slot for a response that
// arrives while decode is stalled.
//   clk, rst_n   - clock, async active-low reset
//   push         - capture push_instr/push_pc (only issued while empty)
//   pop          - release the entry (the decode register took it)
//   flush        - discard the entry; wins over push and pop
//   full         - entry present
//   instr, pc    - stored entry
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic        full_r;
  logic [31:0] instr_r;
  logic [31:0] pc_r;

  // Single storage slot with flush > push > pop priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r  <= 1'b0;
      instr_r <= NOP_INSTR;
      pc_r    <= 32'h0000_0000;
    end else if (flush) begin
      full_r  <= 1'b0;
      instr_r <= NOP_INSTR;
      pc_r    <= 32'h0000_0000;
    end else if (push) begin
      full_r  <= 1'b1;
      instr_r <= push_instr;
      pc_r    <= push_pc;
    end else if (pop) begin
      full_r  <= 1'b0;
    end else begin
      full_r  <= full_r;
    end
  end

  assign full  = full_r;
  assign instr = instr_r;
  assign pc    = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the PC register and decode.
//   clk, rst_n        - clock, async active-low reset
//   pc / npc          - current PC in, next PC out (PC register loads npc every clk)
//   redirect_valid/pc - taken branch/jump from a later stage, highest priority
//   bus (master)      - imem request/response channel and decode-side if_* outputs
// One request is outstanding at a time; a new request is only issued while the
// skid slot is empty, so a response always has somewhere to go.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
)
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   pc,
  output logic [31:0]   npc,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  fetch_unit_if.master  bus
);

  fetch_state_t state_r;
  logic [31:0]  pending_pc_r;
  logic         if_valid_r;
  logic [31:0]  if_instr_r;
  logic [31:0]  if_pc_r;
  logic [31:0]  if_pc4_r;

  logic         req_valid_s;
  logic         req_fire_s;
  logic         rsp_deliver_s;
  logic         load_s;
  logic         skid_push_s;
  logic         skid_pop_s;
  logic         skid_full_s;
  logic [31:0]  skid_instr_s;
  logic [31:0]  skid_pc_s;

  // Request gating plus delivery/skid control derived from the current state.
  always_comb begin
    req_valid_s   = 1'b0;
    rsp_deliver_s = 1'b0;
    if (rst_n && (state_r == FS_REQ) && !redirect_valid && !skid_full_s) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    // A response that coincides with a redirect belongs to the old path.
    if ((state_r == FS_WAIT) && bus.imem_rsp_valid && !redirect_valid) begin
      rsp_deliver_s = 1'b1;
    end else begin
      rsp_deliver_s = 1'b0;
    end
  end

  assign req_fire_s  = req_valid_s && bus.imem_req_ready;
  assign load_s      = !if_valid_r || bus.id_ready;
  assign skid_push_s = rsp_deliver_s && !load_s;
  assign skid_pop_s  = !redirect_valid && load_s && skid_full_s;

  // Next-PC selection: reset vector, redirect, advance on handshake, else hold.
  always_comb begin
    npc = pc;
    if (!rst_n) begin
      npc = RESET_VECTOR;
    end else if (redirect_valid) begin
      npc = redirect_pc;
    end else if (req_fire_s) begin
      npc = pc_plus4(pc);
    end else begin
      npc = pc;
    end
  end

  // Fetch FSM: track the single outstanding request and stale-response drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FS_REQ;
      pending_pc_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        FS_REQ: begin
          if (req_fire_s) begin
            pending_pc_r <= pc;
            state_r      <= FS_WAIT;
          end else begin
            state_r      <= FS_REQ;
          end
        end
        FS_WAIT: begin
          if (redirect_valid && !bus.imem_rsp_valid) begin
            state_r <= FS_DROP;
          end else if (bus.imem_rsp_valid) begin
            state_r <= FS_REQ;
          end else begin
            state_r <= FS_WAIT;
          end
        end
        FS_DROP: begin
          if (bus.imem_rsp_valid) begin
            state_r <= FS_REQ;
          end else begin
            state_r <= FS_DROP;
          end
        end
        default: begin
          state_r <= FS_REQ;
        end
      endcase
    end
  end

  // Decode register: skid entry has priority over a fresh response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_r <= 1'b0;
      if_instr_r <= NOP_INSTR;
      if_pc_r    <= 32'h0000_0000;
      if_pc4_r   <= 32'h0000_0000;
    end else if (redirect_valid) begin
      if_valid_r <= 1'b0;
      if_instr_r <= NOP_INSTR;
    end else if (load_s) begin
      if (skid_full_s) begin
        if_valid_r <= 1'b1;
        if_instr_r <= skid_instr_s;
        if_pc_r    <= skid_pc_s;
        if_pc4_r   <= pc_plus4(skid_pc_s);
      end else if (rsp_deliver_s) begin
        if_valid_r <= 1'b1;
        if_instr_r <= bus.imem_rsp_data;
        if_pc_r    <= pending_pc_r;
        if_pc4_r   <= pc_plus4(pending_pc_r);
      end else begin
        if_valid_r <= 1'b0;
      end
    end else begin
      if_valid_r <= if_valid_r;
    end
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (skid_push_s),
    .pop        (skid_pop_s),
    .flush      (redirect_valid),
    .push_instr (bus.imem_rsp_data),
    .push_pc    (pending_pc_r),
    .full       (skid_full_s),
    .instr      (skid_instr_s),
    .pc         (skid_pc_s)
  );

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = if_valid_r;
  assign bus.if_instr       = if_instr_r;
  assign bus.if_pc          = if_pc_r;
  assign bus.if_pc4         = if_pc4_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Provides the PC register,
// an instruction memory returning addr|0xA5000000 after a programmable latency,
// and a decode sink. Directed scenarios plus a randomized run against an
// in-order stream model (requests and deliveries advance by 4, restart at a
// redirect target).
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int vectors = 0;
  int errors  = 0;

  int          mem_lat;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  fetch_unit_if bus();

  fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .npc            (npc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // PC register: loads npc on every clock.
  always @(posedge clk) pc <= npc;

  // Instruction memory: one response mem_lat cycles after the handshake cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= 32'h0;
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= 32'h0;
    end else begin
      bus.imem_rsp_valid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= mem_addr | 32'hA500_0000;
          mem_busy <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (mem_lat <= 1) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= bus.imem_req_addr | 32'hA500_0000;
        end else begin
          mem_busy <= 1'b1;
          mem_cnt  <= mem_lat - 1;
          mem_addr <= bus.imem_req_addr;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_if_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.if_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset_stream();
    mem_lat = 1;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    bus.imem_req_ready = 1'b1; bus.id_ready = 1'b1;
    repeat (3) tick();
    #1;
    vectors++; if (npc !== 32'h0) begin errors++; $display("FAIL rst_npc got=%h exp=%h", npc, 32'h0); end
    vectors++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got=%b exp=0", bus.if_valid); end
    vectors++; if (bus.if_instr !== NOP_INSTR) begin errors++; $display("FAIL rst_if_instr got=%h exp=%h", bus.if_instr, NOP_INSTR); end
    vectors++; if (bus.if_pc !== 32'h0 || bus.if_pc4 !== 32'h0) begin errors++; $display("FAIL rst_if_pc got=%h/%h exp=0/0", bus.if_pc, bus.if_pc4); end
    vectors++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", bus.imem_req_valid); end
    rst_n = 1'b1; #1;
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0 || npc !== 32'h4) begin errors++; $display("FAIL stream_req0 got v=%b a=%h npc=%h exp v=1 a=0 npc=4", bus.imem_req_valid, bus.imem_req_addr, npc); end
    tick();
    vectors++; if (bus.imem_req_valid !== 1'b0 || npc !== 32'h4) begin errors++; $display("FAIL stream_wait got v=%b npc=%h exp v=0 npc=4", bus.imem_req_valid, npc); end
    tick();
    vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_pc4 !== 32'h4 || bus.if_instr !== 32'hA500_0000) begin errors++; $display("FAIL stream_del0 got v=%b pc=%h pc4=%h i=%h exp 1/0/4/a5000000", bus.if_valid, bus.if_pc, bus.if_pc4, bus.if_instr); end
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h4) begin errors++; $display("FAIL stream_req4 got v=%b a=%h exp 1/4", bus.imem_req_valid, bus.imem_req_addr); end
    tick(); tick();
    vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4 || bus.if_pc4 !== 32'h8 || bus.if_instr !== 32'hA500_0004) begin errors++; $display("FAIL stream_del4 got v=%b pc=%h pc4=%h i=%h exp 1/4/8/a5000004", bus.if_valid, bus.if_pc, bus.if_pc4, bus.if_instr); end
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8) begin errors++; $display("FAIL stream_req8 got v=%b a=%h exp 1/8", bus.imem_req_valid, bus.imem_req_addr); end
    tick(); tick();
    vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8 || bus.if_pc4 !== 32'hC) begin errors++; $display("FAIL stream_del8 got v=%b pc=%h pc4=%h exp 1/8/c", bus.if_valid, bus.if_pc, bus.if_pc4); end
  endtask

  task automatic test_stall();
    mem_lat = 1;
    do_reset();
    tick(); tick();
    bus.id_ready = 1'b0; #1;
    tick(); tick();
    vectors++; if (bus.imem_req_valid !== 1'b0 || npc !== 32'h8) begin errors++; $display("FAIL stall_hold1 got v=%b npc=%h exp 0/8", bus.imem_req_valid, npc); end
    vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin errors++; $display("FAIL stall_out got v=%b pc=%h exp 1/0", bus.if_valid, bus.if_pc); end
    tick();
    vectors++; if (bus.imem_req_valid !== 1'b0 || npc !== 32'h8) begin errors++; $display("FAIL stall_hold2 got v=%b npc=%h exp 0/8", bus.imem_req_valid, npc); end
    tick();
    bus.id_ready = 1'b1; #1;
    tick();
    vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4 || bus.if_instr !== 32'hA500_0004) begin errors++; $display("FAIL stall_rel4 got v=%b pc=%h i=%h exp 1/4/a5000004", bus.if_valid, bus.if_pc, bus.if_instr); end
    tick();
    vectors++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL stall_nodup got v=%b exp 0", bus.if_valid); end
    tick();
    vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8) begin errors++; $display("FAIL stall_rel8 got v=%b pc=%h exp 1/8", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_redirect_wait();
    bit found;
    bit saw;
    mem_lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.imem_req_valid && bus.imem_req_addr == 32'h8) found = 1'b1;
      else tick();
    end
    vectors++; if (!found) begin errors++; $display("FAIL rdw_hs8 timeout got none exp handshake at 8"); end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    vectors++; if (npc !== 32'h100) begin errors++; $display("FAIL rdw_npc got=%h exp=100", npc); end
    tick();
    redirect_valid = 1'b0; #1;
    vectors++; if (bus.if_valid !== 1'b0 || bus.if_instr !== NOP_INSTR) begin errors++; $display("FAIL rdw_clear got v=%b i=%h exp 0/0", bus.if_valid, bus.if_instr); end
    found = 1'b0; saw = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.imem_req_valid) found = 1'b1;
      else begin
        if (bus.if_valid) saw = 1'b1;
        tick();
      end
    end
    vectors++; if (!found || bus.imem_req_addr !== 32'h100 || saw) begin errors++; $display("FAIL rdw_req got found=%b a=%h stale=%b exp 1/100/0", found, bus.imem_req_addr, saw); end
    wait_if_valid(found);
    vectors++; if (!found || bus.if_pc !== 32'h100 || bus.if_instr !== 32'hA500_0100) begin errors++; $display("FAIL rdw_del got ok=%b pc=%h i=%h exp 1/100/a5000100", found, bus.if_pc, bus.if_instr); end
  endtask

  task automatic test_flush_full();
    bit ok;
    mem_lat = 1;
    do_reset();
    tick(); tick();
    bus.id_ready = 1'b0; #1;
    tick(); tick();
    vectors++; if (bus.if_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_pre got v=%b req=%b exp 1/0", bus.if_valid, bus.imem_req_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    vectors++; if (npc !== 32'h200) begin errors++; $display("FAIL flush_npc got=%h exp=200", npc); end
    tick();
    redirect_valid = 1'b0; bus.id_ready = 1'b1; #1;
    vectors++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0) begin errors++; $display("FAIL flush_out got v=%b i=%h exp 0/0", bus.if_valid, bus.if_instr); end
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin errors++; $display("FAIL flush_skid got req=%b a=%h exp 1/200", bus.imem_req_valid, bus.imem_req_addr); end
    wait_if_valid(ok);
    vectors++; if (!ok || bus.if_pc !== 32'h200) begin errors++; $display("FAIL flush_del got ok=%b pc=%h exp 1/200", ok, bus.if_pc); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    mem_lat = 2;
    do_reset();
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
    tick();
    redirect_valid = 1'b0; #1;
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h300 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL simw got req=%b a=%h v=%b exp 1/300/0", bus.imem_req_valid, bus.imem_req_addr, bus.if_valid); end
    mem_lat = 3;
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
    tick();
    redirect_valid = 1'b0; #1;
    vectors++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL simd_drop got req=%b exp 0", bus.imem_req_valid); end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h400; #1;
    tick();
    redirect_valid = 1'b0; #1;
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h400 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL simd got req=%b a=%h v=%b exp 1/400/0", bus.imem_req_valid, bus.imem_req_addr, bus.if_valid); end
    wait_if_valid(ok);
    vectors++; if (!ok || bus.if_pc !== 32'h400) begin errors++; $display("FAIL simd_del got ok=%b pc=%h exp 1/400", ok, bus.if_pc); end
  endtask

  task automatic test_wrap_reset();
    bit ok;
    mem_lat = 1;
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    tick();
    redirect_valid = 1'b0; #1;
    vectors++; if (bus.imem_req_addr !== 32'hFFFF_FFFC || npc !== 32'h0) begin errors++; $display("FAIL wrap_npc got a=%h npc=%h exp fffffffc/0", bus.imem_req_addr, npc); end
    tick(); tick();
    vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC || bus.if_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got v=%b pc=%h pc4=%h exp 1/fffffffc/0", bus.if_valid, bus.if_pc, bus.if_pc4); end
    do_reset();
    tick(); tick();
    bus.id_ready = 1'b0; mem_lat = 4; #1;
    tick();
    vectors++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre got v=%b exp 1", bus.if_valid); end
    rst_n = 1'b0; #1;
    vectors++; if (bus.if_valid !== 1'b0 || npc !== 32'h0 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL mrst got v=%b npc=%h req=%b exp 0/0/0", bus.if_valid, npc, bus.imem_req_valid); end
    tick(); tick();
    rst_n = 1'b1; bus.id_ready = 1'b1; mem_lat = 1; #1;
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL mrst_req got req=%b a=%h exp 1/0", bus.imem_req_valid, bus.imem_req_addr); end
    wait_if_valid(ok);
    vectors++; if (!ok || bus.if_pc !== 32'h0) begin errors++; $display("FAIL mrst_del got ok=%b pc=%h exp 1/0", ok, bus.if_pc); end
  endtask

  task automatic test_random();
    logic [31:0] next_req;
    logic [31:0] next_del;
    bit prev_redir;
    int delivered;
    mem_lat = 1;
    do_reset();
    next_req = 32'h0; next_del = 32'h0; prev_redir = 1'b0; delivered = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid     = ($urandom_range(0, 15) == 0);
      redirect_pc        = $urandom & 32'hFFFF_FFFC;
      mem_lat            = $urandom_range(1, 3);
      #1;
      if (prev_redir) begin
        vectors++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush cyc=%0d got v=%b exp 0", cyc, bus.if_valid); end
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        vectors++; if (bus.imem_req_addr !== next_req || bus.imem_req_addr !== pc) begin errors++; $display("FAIL rnd_req cyc=%0d got a=%h exp %h", cyc, bus.imem_req_addr, next_req); end
        next_req = next_req + 32'd4;
      end
      if (bus.if_valid && bus.id_ready && !redirect_valid) begin
        vectors++; if (bus.if_pc !== next_del || bus.if_instr !== (next_del | 32'hA500_0000) || bus.if_pc4 !== next_del + 32'd4) begin errors++; $display("FAIL rnd_del cyc=%0d got pc=%h i=%h pc4=%h exp pc=%h", cyc, bus.if_pc, bus.if_instr, bus.if_pc4, next_del); end
        next_del = next_del + 32'd4;
        delivered++;
      end
      if (redirect_valid) begin
        next_req = redirect_pc;
        next_del = redirect_pc;
      end
      prev_redir = redirect_valid;
      tick();
    end
    redirect_valid = 1'b0;
    vectors++; if (delivered < 20) begin errors++; $display("FAIL rnd_progress got %0d deliveries exp >=20", delivered); end
  endtask

  initial begin
    test_reset_stream();
    test_stall();
    test_redirect_wait();
    test_flush_full();
    test_simultaneous();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
